// File: rtl/sprite_pkg.sv
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared constants, register map and FSM encoding for sprite_dma.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int SPR_COUNT = 16;
    localparam int SPR_BYTES = 4;
    localparam int SRC_AW    = 16;
    localparam int DST_AW    = 7;

    localparam logic [2:0] REG_BASE_LO = 3'd0;
    localparam logic [2:0] REG_BASE_HI = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CSUM    = 3'd4;

    localparam int CTRL_AUTO    = 0;
    localparam int CTRL_START   = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_dma_if.sv
// ============================================================================
// Module   : sprite_dma_if
// Purpose  : Main-RAM read handshake plus sprite RAM write port of the DMA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_dma_if #(
    parameter int SRC_AW = sprite_pkg::SRC_AW,
    parameter int DST_AW = sprite_pkg::DST_AW
) ();

    logic              bus_req;
    logic              bus_gnt;
    logic [SRC_AW-1:0] src_addr;
    logic [7:0]        src_data;
    logic [DST_AW-1:0] spriteram_wr_addr;
    logic              spriteram_wr;
    logic [7:0]        spriteram_data_in;

    modport master (
        output bus_req, src_addr, spriteram_wr_addr, spriteram_wr, spriteram_data_in,
        input  bus_gnt, src_data
    );

    modport slave (
        input  bus_req, src_addr, spriteram_wr_addr, spriteram_wr, spriteram_data_in,
        output bus_gnt, src_data
    );

endinterface

`default_nettype wire

// File: rtl/sprite_dma_regs.sv
// ============================================================================
// Module   : sprite_dma_regs
// Purpose  : CPU register file: base, ctrl, status flags, start detection and
//            read-back mux for sprite_dma.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_dma_regs (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        cpu_cs,
    input  wire logic        cpu_wr,
    input  wire logic [2:0]  cpu_addr,
    input  wire logic [7:0]  cpu_din,
    output logic      [7:0]  cpu_dout,
    input  wire logic        vblank_edge,
    input  wire logic        busy,
    input  wire logic        done_set,
    input  wire logic [7:0]  csum,
    output logic      [15:0] base,
    output logic             start_cond,
    output logic             done_irq
);
    import sprite_pkg::*;

    logic [15:0] base_q, base_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic        done_flag_q, done_flag_d;
    logic        overrun_q, overrun_d;

    logic        reg_wr;
    logic        ctrl_wr;
    logic        status_wr;

    assign reg_wr    = cpu_cs & cpu_wr;
    assign ctrl_wr   = reg_wr & (cpu_addr == REG_CTRL);
    assign status_wr = reg_wr & (cpu_addr == REG_STATUS);

    // Start bit is a write strobe, never stored.
    assign start_cond = (vblank_edge & auto_q) | (ctrl_wr & cpu_din[CTRL_START]);

    always_comb begin
        base_d   = base_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        if (reg_wr && (cpu_addr == REG_BASE_LO)) base_d[7:0]  = cpu_din;
        if (reg_wr && (cpu_addr == REG_BASE_HI)) base_d[15:8] = cpu_din;
        if (ctrl_wr) begin
            auto_d   = cpu_din[CTRL_AUTO];
            irq_en_d = cpu_din[CTRL_IRQ_EN];
        end
        // Set has priority over a same-cycle write-1 clear.
        done_flag_d = done_set |
                      (done_flag_q & ~(status_wr & cpu_din[STAT_DONE]));
        overrun_d   = (start_cond & busy) |
                      (overrun_q & ~(status_wr & cpu_din[STAT_OVERRUN]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q      <= '0;
            auto_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_flag_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            base_q      <= base_d;
            auto_q      <= auto_d;
            irq_en_q    <= irq_en_d;
            done_flag_q <= done_flag_d;
            overrun_q   <= overrun_d;
        end
    end

    assign base     = base_q;
    assign done_irq = done_flag_q & irq_en_q;

    always_comb begin
        cpu_dout = 8'h00;
        case (cpu_addr)
            REG_BASE_LO: cpu_dout = base_q[7:0];
            REG_BASE_HI: cpu_dout = base_q[15:8];
            REG_CTRL: begin
                cpu_dout[CTRL_AUTO]   = auto_q;
                cpu_dout[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_STATUS: begin
                cpu_dout[STAT_BUSY]    = busy;
                cpu_dout[STAT_DONE]    = done_flag_q;
                cpu_dout[STAT_OVERRUN] = overrun_q;
            end
            REG_CSUM: cpu_dout = csum;
            default:  cpu_dout = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sprite_dma.sv
// ============================================================================
// Module   : sprite_dma
// Purpose  : Copies a 64-byte sprite table from main RAM into sprite RAM on a
//            vblank edge or CPU start. Optional SPRITE_DMA_CHECKSUM_EN adds an
//            XOR checksum of the written bytes at register 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_dma #(
    parameter int SPR_COUNT = sprite_pkg::SPR_COUNT,
    parameter int SPR_BYTES = sprite_pkg::SPR_BYTES,
    parameter int SRC_AW    = sprite_pkg::SRC_AW,
    parameter int DST_AW    = sprite_pkg::DST_AW
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       vblank,
    input  wire logic       cpu_cs,
    input  wire logic       cpu_wr,
    input  wire logic [2:0] cpu_addr,
    input  wire logic [7:0] cpu_din,
    output logic      [7:0] cpu_dout,
    sprite_dma_if.master    bus,
    output logic            busy,
    output logic            done_irq
);
    import sprite_pkg::*;

    localparam logic [DST_AW-1:0] XFER_LEN = DST_AW'(SPR_COUNT * SPR_BYTES);

    dma_state_e        state_q, state_d;
    logic [SRC_AW-1:0] src_ptr_q, src_ptr_d;
    logic [DST_AW-1:0] issue_cnt_q, issue_cnt_d;
    logic [DST_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              vblank_q;

    logic              vblank_edge;
    logic              start_cond;
    logic              start_go;
    logic              issue;
    logic              bus_req_w;
    logic              busy_w;
    logic              spr_wr;
    logic              done_set;
    logic [15:0]       base;
    logic [7:0]        csum;

    assign vblank_edge = vblank & ~vblank_q;

    sprite_dma_regs u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_cs      (cpu_cs),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .vblank_edge (vblank_edge),
        .busy        (busy_w),
        .done_set    (done_set),
        .csum        (csum),
        .base        (base),
        .start_cond  (start_cond),
        .done_irq    (done_irq)
    );

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rd_pend_d   = 1'b0;
        bus_req_w   = 1'b0;
        busy_w      = 1'b0;
        spr_wr      = 1'b0;
        done_set    = 1'b0;
        issue       = 1'b0;
        start_go    = 1'b0;
        case (state_q)
            // DONE also accepts a start so back-to-back triggers are not lost.
            ST_IDLE, ST_DONE: begin
                done_set = (state_q == ST_DONE);
                state_d  = ST_IDLE;
                if (start_cond) begin
                    start_go    = 1'b1;
                    src_ptr_d   = base[SRC_AW-1:0];
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                busy_w    = 1'b1;
                bus_req_w = 1'b1;
                if (bus.bus_gnt) begin
                    issue   = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                busy_w    = 1'b1;
                bus_req_w = (issue_cnt_q < XFER_LEN);
                issue     = bus.bus_gnt & bus_req_w;
                spr_wr    = rd_pend_q;
                if (rd_pend_q) wr_cnt_d = wr_cnt_q + DST_AW'(1);
                if (wr_cnt_q == XFER_LEN) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // rd_pend marks that src_data carries the byte addressed last cycle.
        if (issue) begin
            src_ptr_d   = src_ptr_q + SRC_AW'(1);
            issue_cnt_d = issue_cnt_q + DST_AW'(1);
            rd_pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            src_ptr_q   <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            rd_pend_q   <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_pend_q   <= rd_pend_d;
            vblank_q    <= vblank;
        end
    end

`ifdef SPRITE_DMA_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_go)    csum_d = 8'h00;
        else if (spr_wr) csum_d = csum_step(csum_q, bus.src_data);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= 8'h00;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`else
    assign csum = 8'h00;
`endif

    assign busy                  = busy_w;
    assign bus.bus_req           = bus_req_w;
    assign bus.src_addr          = src_ptr_q;
    assign bus.spriteram_wr      = spr_wr;
    assign bus.spriteram_wr_addr = wr_cnt_q;
    assign bus.spriteram_data_in = spr_wr ? bus.src_data : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_sprite_dma.sv
// ============================================================================
// Module   : tb_sprite_dma
// Purpose  : Self-checking bench for sprite_dma against a table-copy model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_dma;
    import sprite_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vblank = 1'b0;
    logic       cpu_cs = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [2:0] cpu_addr = 3'd0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic       busy;
    logic       done_irq;

    sprite_dma_if bus_if ();

    sprite_dma dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vblank   (vblank),
        .cpu_cs   (cpu_cs),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .bus      (bus_if),
        .busy     (busy),
        .done_irq (done_irq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          gnt_mode = 0;
    int          gnt_phase = 0;
    int          busy_cycles = 0;
    bit          irq_seen = 1'b0;
    bit          pend_valid = 1'b0;
    logic [15:0] pend_addr = 16'h0;
    logic [7:0]  mem [0:65535];
    logic [15:0] iss_q [$];
    logic [6:0]  wra_q [$];
    logic [7:0]  wrd_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Arbiter grant patterns: 0 always, 1 pattern 1,0,0,1, 2 random ~75%.
    initial begin
        bus_if.bus_gnt = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (gnt_mode)
                0: bus_if.bus_gnt = 1'b1;
                1: begin
                    bus_if.bus_gnt = (gnt_phase == 0) || (gnt_phase == 3);
                    gnt_phase = (gnt_phase + 1) % 4;
                end
                2: bus_if.bus_gnt = ($urandom_range(0, 3) != 0);
                default: bus_if.bus_gnt = 1'b0;
            endcase
        end
    end

    // Main RAM: data for an address granted in one cycle appears the next.
    always @(posedge clk) begin
        #2;
        bus_if.src_data = pend_valid ? mem[pend_addr] : 8'hEE;
    end

    always @(negedge clk) begin
        if (reset_n && bus_if.bus_req && bus_if.bus_gnt) begin
            pend_valid = 1'b1;
            pend_addr  = bus_if.src_addr;
            iss_q.push_back(bus_if.src_addr);
        end else begin
            pend_valid = 1'b0;
        end
        if (bus_if.spriteram_wr) begin
            wra_q.push_back(bus_if.spriteram_wr_addr);
            wrd_q.push_back(bus_if.spriteram_data_in);
        end
        if (busy) busy_cycles++;
        if (done_irq) irq_seen = 1'b1;
    end

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
        #2;
        d = cpu_dout;
        cpu_cs = 1'b0;
    endtask

    task automatic set_base(input logic [15:0] b);
        cpu_write(REG_BASE_LO, b[7:0]);
        cpu_write(REG_BASE_HI, b[15:8]);
    endtask

    task automatic clear_mon();
        iss_q.delete(); wra_q.delete(); wrd_q.delete();
        busy_cycles = 0;
    endtask

    task automatic wait_xfer();
        int n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check_eq("xfer_timeout", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Model: sprite byte i must equal main RAM at (base+i) mod 64K, in order.
    task automatic verify_xfer(input logic [15:0] b);
        int n;
        logic [15:0] a;
        logic [7:0]  x;
        logic [7:0]  r;
        x = 8'h00;
        check_eq("wr_count", wra_q.size(), 64);
        check_eq("iss_count", iss_q.size(), 64);
        n = (wra_q.size() < 64) ? wra_q.size() : 64;
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            check_eq("wr_addr", {25'd0, wra_q[i]}, i);
            check_eq("wr_data", {24'd0, wrd_q[i]}, {24'd0, mem[a]});
        end
        n = (iss_q.size() < 64) ? iss_q.size() : 64;
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            check_eq("src_addr", {16'd0, iss_q[i]}, {16'd0, a});
        end
        for (int i = 0; i < 64; i++) begin
            a = b + 16'(i);
            x = x ^ mem[a];
        end
        cpu_read(REG_CSUM, r);
`ifdef SPRITE_DMA_CHECKSUM_EN
        check_eq("csum", {24'd0, r}, {24'd0, x});
`else
        check_eq("csum_off", {24'd0, r}, 32'd0);
`endif
    endtask

    task automatic fill_rand(input logic [15:0] b);
        logic [15:0] a;
        for (int i = 0; i < 64; i++) begin
            a = b + 16'(i);
            mem[a] = 8'($urandom);
        end
    endtask

    initial begin
        logic [7:0]  r;
        logic [15:0] b;
        int          n;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bus_req", {31'd0, bus_if.bus_req}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_spr_wr", {31'd0, bus_if.spriteram_wr}, 0);
        check_eq("rst_irq", {31'd0, done_irq}, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_read(3'(i), r);
            check_eq("rst_reg", {24'd0, r}, 0);
        end

        // Auto transfer on vblank edge, grant tied high
        gnt_mode = 0;
        set_base(16'h1000);
        cpu_write(REG_CTRL, 8'h01);
        clear_mon();
        @(posedge clk); #1; vblank = 1'b1;
        wait_xfer();
        verify_xfer(16'h1000);
        check_eq("busy_cycles_range", {31'd0, (busy_cycles >= 65 && busy_cycles <= 67)}, 1);
        cpu_read(REG_STATUS, r);
        check_eq("status_done", {24'd0, r}, 32'h02);
        vblank = 1'b0;
        cpu_write(REG_CTRL, 8'h00);
        cpu_write(REG_STATUS, 8'h06);

        // Manual start with grant pattern 1,0,0,1
        gnt_mode = 1; gnt_phase = 0;
        clear_mon();
        cpu_write(REG_CTRL, 8'h02);
        wait_xfer();
        verify_xfer(16'h1000);
        cpu_read(REG_CTRL, r);
        check_eq("ctrl_start_reads0", {24'd0, r}, 0);
        cpu_write(REG_STATUS, 8'h06);

        // Start coincident with vblank edge: exactly one transfer
        gnt_mode = 0;
        cpu_write(REG_CTRL, 8'h01);
        clear_mon();
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = REG_CTRL; cpu_din = 8'h03; vblank = 1'b1;
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        wait_xfer();
        repeat (20) @(negedge clk);
        verify_xfer(16'h1000);
        cpu_read(REG_STATUS, r);
        check_eq("status_no_overrun", {24'd0, r}, 32'h02);
        vblank = 1'b0;
        cpu_write(REG_CTRL, 8'h00);
        cpu_write(REG_STATUS, 8'h06);

        // Second start mid-transfer sets overrun only
        clear_mon();
        cpu_write(REG_CTRL, 8'h02);
        repeat (20) @(negedge clk);
        cpu_write(REG_CTRL, 8'h02);
        wait_xfer();
        repeat (20) @(negedge clk);
        verify_xfer(16'h1000);
        cpu_read(REG_STATUS, r);
        check_eq("status_overrun", {24'd0, r}, 32'h06);
        cpu_write(REG_STATUS, 8'h06);
        cpu_read(REG_STATUS, r);
        check_eq("status_cleared", {24'd0, r}, 0);

        // Source pointer wraps at 64K
        fill_rand(16'hFFF0);
        set_base(16'hFFF0);
        clear_mon();
        cpu_write(REG_CTRL, 8'h02);
        wait_xfer();
        verify_xfer(16'hFFF0);
        cpu_write(REG_STATUS, 8'h06);

        // Interrupt enabled
        irq_seen = 1'b0;
        clear_mon();
        cpu_write(REG_CTRL, 8'h06);
        wait_xfer();
        check_eq("irq_high", {31'd0, done_irq}, 1);
        verify_xfer(16'hFFF0);
        check_eq("irq_held", {31'd0, done_irq}, 1);
        cpu_write(REG_STATUS, 8'h02);
        @(negedge clk);
        check_eq("irq_cleared", {31'd0, done_irq}, 0);

        // Interrupt disabled
        cpu_write(REG_CTRL, 8'h00);
        irq_seen = 1'b0;
        clear_mon();
        cpu_write(REG_CTRL, 8'h02);
        wait_xfer();
        check_eq("irq_never", {31'd0, irq_seen}, 0);
        cpu_read(REG_STATUS, r);
        check_eq("status_done_noirq", {24'd0, r}, 32'h02);
        cpu_write(REG_STATUS, 8'h06);

        // Randomised transfers: base, data, grant and trigger source
        for (int t = 0; t < 5; t++) begin
            b = 16'($urandom);
            fill_rand(b);
            set_base(b);
            gnt_mode = 2;
            clear_mon();
            if ($urandom_range(0, 1) == 0) begin
                cpu_write(REG_CTRL, 8'h02);
            end else begin
                cpu_write(REG_CTRL, 8'h01);
                @(posedge clk); #1; vblank = 1'b1;
            end
            wait_xfer();
            verify_xfer(b);
            vblank = 1'b0;
            cpu_write(REG_CTRL, 8'h00);
            cpu_write(REG_STATUS, 8'h06);
        end

        // Bytes 0x00..0x3F (XOR of these is zero)
        gnt_mode = 0;
        for (int i = 0; i < 64; i++) mem[16'h2000 + i] = 8'(i);
        set_base(16'h2000);
        clear_mon();
        cpu_write(REG_CTRL, 8'h02);
        wait_xfer();
        verify_xfer(16'h2000);

        // Reset asserted after the 20th byte
        cpu_write(REG_CTRL, 8'h04);
        clear_mon();
        cpu_write(REG_CTRL, 8'h06);
        n = 0;
        while (wra_q.size() < 20 && n < 500) begin @(negedge clk); #1; n++; end
        check_eq("reached_byte20", wra_q.size(), 20);
        reset_n = 1'b0;
        #1;
        check_eq("abort_spr_wr", {31'd0, bus_if.spriteram_wr}, 0);
        check_eq("abort_bus_req", {31'd0, bus_if.bus_req}, 0);
        check_eq("abort_busy", {31'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("abort_no_more_wr", wra_q.size(), 20);
        check_eq("abort_idle_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 5; i++) begin
            cpu_read(3'(i), r);
            check_eq("post_rst_reg", {24'd0, r}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_dma.md
Name: sprite_dma

Overview:
- Sequencer that fills the sprite attribute RAM (16 sprites × 4 bytes) from a CPU-selected table in main RAM.
- Transfers run automatically on each vblank rising edge and/or on a CPU command.
- Source reads go through the main-RAM arbiter with a req/gnt handshake. Destination is the sprite RAM write port, which the sprite engine only reads.
- Gives race-free sprite updates: the CPU edits a shadow table at any time, and sprite RAM changes only inside vblank.

Parameters:
- SPR_COUNT, 16, number of sprite entries
- SPR_BYTES, 4, bytes per entry; transfer length N = SPR_COUNT*SPR_BYTES = 64
- SRC_AW, 16, main-RAM address width
- DST_AW, 7, sprite RAM address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vblank  in  1  vertical blank level from video timing
- cpu_cs  in  1  register select
- cpu_wr  in  1  register write strobe; valid when cpu_cs=1
- cpu_addr  in  3  register offset
- cpu_din  in  8  register write data
- cpu_dout  out  8  register read data; combinational from cpu_addr
- bus_req  out  1  request to main-RAM arbiter
- bus_gnt  in  1  arbiter grant
- src_addr  out  SRC_AW  main-RAM read address
- src_data  in  8  main-RAM read data; valid 1 cycle after the address is issued under grant
- spriteram_wr_addr  out  DST_AW  sprite RAM write address
- spriteram_wr  out  1  sprite RAM write enable
- spriteram_data_in  out  8  sprite RAM write data
- busy  out  1  transfer in progress
- done_irq  out  1  level interrupt = done_flag & irq_en

Behaviour:
- Registers:
  - 0: base[7:0] (R/W)
  - 1: base[15:8] (R/W)
  - 2: ctrl (R/W). bit0 auto (start on vblank edge), bit1 start (write-1 pulse; reads 0), bit2 irq_en.
  - 3: status. Read: bit0 busy, bit1 done_flag, bit2 overrun. Write-1 clears bit1 and bit2.
  - 4: checksum (see Optional Feature).
  - 5-7: read 0.
- Reset: all registers 0. All outputs 0, state IDLE.
- vblank is registered once. An edge is detected when vblank=1 and vblank_q=0.
- Start condition: (edge & auto) | start pulse.
  - Simultaneous edge and start pulse trigger one transfer.
  - A start condition while busy is ignored and sets overrun.
- IDLE, on start:
  - Latch base into src_ptr; clear count.
  - Next state REQ; busy=1 and bus_req=1 from the next cycle.
- REQ:
  - bus_req=1.
  - When bus_gnt=1: issue src_addr=src_ptr, src_ptr++, issue_cnt++, rd_pend<=1. Go to XFER.
- XFER: one byte per granted cycle, pipelined.
  - Each cycle with rd_pend=1: spriteram_wr=1, spriteram_wr_addr=wr_cnt, spriteram_data_in=src_data, wr_cnt++.
  - Each cycle with bus_gnt=1 and issue_cnt<N: issue the next address.
  - rd_pend for the next cycle = whether an address was issued this cycle.
  - bus_req stays high until issue_cnt=N, then drops the following cycle.
- Grant dropped mid-transfer:
  - Stop issuing; the in-flight read still completes and is written.
  - Resume when bus_gnt returns; no byte is skipped or duplicated.
- Completion: wr_cnt=N goes to DONE (1 cycle): busy=0, done_flag=1, then IDLE.
- Ideal timing: with bus_gnt held high, the transfer occupies N+1 cycles from the first issue to the last write.
- Arithmetic:
  - src_ptr wraps modulo 2^SRC_AW (base 0xFFF0 reads 0xFFF0..0xFFFF, then 0x0000..).
  - wr_cnt and issue_cnt are DST_AW bits wide; spriteram_wr_addr never exceeds N-1.
- Base writes while busy update the register only; the next transfer uses the new value.
- Clearing auto while busy does not abort the transfer.
- A done_flag set and a write-1 clear in the same cycle: set wins.
- reset_n asserted mid-transfer aborts immediately. Sprite RAM keeps any partially written bytes.

Optional Feature:
- Macro SPRITE_DMA_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR of every byte written is accumulated.
  - It is cleared at transfer start and readable at register 4 once done_flag=1.
  - Enables software verification of the sprite table.
- When undefined: register 4 reads 0 and no accumulator logic exists.

Decomposition:
- Shared package sprite_pkg:
  - Register offsets (REG_BASE_LO…REG_CSUM).
  - ctrl/status bit indices.
  - SPR_COUNT, SPR_BYTES.
  - State encoding (IDLE, REQ, XFER, DONE).
- One sub-module: sprite_dma_regs.
  - CPU register file, start pulse, overrun/done set-clear priority, cpu_dout mux.
  - The transfer FSM and counters stay in sprite_dma.

Test Plan:
- base=0x1000, auto=1, gnt tied 1, memory byte = addr[7:0]^0x5A; raise vblank:
  - 64 writes, addr 0..63, data (0x00..0x3F)^0x5A.
  - busy high for 65+2 cycles; done_flag=1.
- Manual start with gnt toggling 1,0,0,1 repeatedly: all 64 bytes written exactly once, in order; src_addr sequence contiguous.
- Start written to ctrl in the same cycle as a vblank edge: one transfer only, overrun=0. A second start mid-transfer: overrun=1, still 64 writes. Write 0x06 to status: both flags cleared.
- base=0xFFF0: src_addr reads 0xFFF0..0xFFFF, then 0x0000..0x002F.
- irq_en=1: done_irq rises with done_flag and stays high until status bit1 is written 1. With irq_en=0, done_irq stays 0.
- reset_n low at byte 20: spriteram_wr, bus_req and busy go 0 immediately. After release, state is IDLE and registers are 0. With SPRITE_DMA_CHECKSUM_EN, a full transfer of bytes 0x00..0x3F yields register 4 = 0x00.
